// File: rtl/ll_rd_ctrl.sv
// rtl/ll_rd_ctrl.sv - linked-list read/pop controller: fetch node data + successor, free node, respond.
// Optional WAIT_RD watchdog enabled by defining LL_RD_TMO_EN.
module ll_rd_ctrl #(
`ifdef LL_RD_TMO_EN
    parameter int                 TMO_CYC    = 64,
`endif
    parameter int                 PTR_WD     = 8,
    parameter int                 RD_DATA_WD = 32,
    parameter logic [PTR_WD-1:0]  NULL_PTR   = {PTR_WD{1'b1}}
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rd_req,
    input  logic [PTR_WD-1:0]     rd_ptr,
    output logic                  rd_ctrl_fsm_ready,
    output logic                  rd_req2ll_data_mem,
    output logic [PTR_WD-1:0]     rd_addr2ll_data_mem,
    input  logic [RD_DATA_WD-1:0] rd_data_from_ll_data_mem,
    input  logic                  rd_data_from_ll_data_mem_vld,
    output logic                  nxt_ptr_rd_req,
    output logic [PTR_WD-1:0]     nxt_ptr_rd_addr,
    input  logic [PTR_WD-1:0]     nxt_ptr_rd_data,
    input  logic                  nxt_ptr_rd_vld,
    output logic [PTR_WD-1:0]     free_ptr,
    output logic                  free_ptr_vld,
    input  logic                  free_ptr_ack,
    output logic [RD_DATA_WD-1:0] rd_data_out,
    output logic [PTR_WD-1:0]     rd_nxt_ptr_out,
    output logic                  rd_err,
    output logic                  rd_resp_vld,
    input  logic                  rd_resp_rdy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RD,
        S_FREE,
        S_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_nxt_state;

    logic [PTR_WD-1:0]       r_ptr;
    logic [RD_DATA_WD-1:0]   r_data;
    logic [PTR_WD-1:0]       r_nxt;
    logic                    r_err;
    logic                    r_pend_data;
    logic                    r_pend_nxt;
    logic                    r_ready;
    logic                    r_issue;
    logic                    r_free_vld;
    logic                    r_resp_vld;

    logic                    w_data_hit;
    logic                    w_nxt_hit;
    logic                    w_data_left;
    logic                    w_nxt_left;
    logic                    w_tmo;

    // A strobe only counts while its read is outstanding; anything else is stale.
    assign w_data_hit  = rd_data_from_ll_data_mem_vld & r_pend_data;
    assign w_nxt_hit   = nxt_ptr_rd_vld & r_pend_nxt;
    assign w_data_left = r_pend_data & ~rd_data_from_ll_data_mem_vld;
    assign w_nxt_left  = r_pend_nxt & ~nxt_ptr_rd_vld;

`ifdef LL_RD_TMO_EN
    localparam int TMO_CNT_WD = $clog2(TMO_CYC + 1);

    logic [TMO_CNT_WD-1:0]   r_tmo_cnt;

    assign w_tmo = (r_state == S_WAIT_RD) && (r_tmo_cnt == TMO_CNT_WD'(TMO_CYC - 1))
                   && (w_data_left || w_nxt_left);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_tmo_cnt <= '0;
        end else if (r_state == S_WAIT_RD) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (rd_req) begin
                    w_nxt_state = (rd_ptr == NULL_PTR) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_nxt_state = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (!w_data_left && !w_nxt_left) begin
                    w_nxt_state = S_FREE;
                end else if (w_tmo) begin
                    w_nxt_state = S_RESP;
                end
            end
            S_FREE: begin
                if (free_ptr_ack) begin
                    w_nxt_state = S_RESP;
                end
            end
            S_RESP: begin
                if (rd_resp_rdy) begin
                    w_nxt_state = S_IDLE;
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // Strobes and valids are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            r_data      <= '0;
            r_nxt       <= '0;
            r_err       <= 1'b0;
            r_pend_data <= 1'b0;
            r_pend_nxt  <= 1'b0;
            r_ready     <= 1'b1;
            r_issue     <= 1'b0;
            r_free_vld  <= 1'b0;
            r_resp_vld  <= 1'b0;
        end else begin
            r_ready    <= (w_nxt_state == S_IDLE);
            r_issue    <= (w_nxt_state == S_ISSUE);
            r_free_vld <= (w_nxt_state == S_FREE);
            r_resp_vld <= (w_nxt_state == S_RESP);
            case (r_state)
                S_IDLE: begin
                    if (rd_req) begin
                        r_ptr  <= rd_ptr;
                        r_data <= '0;
                        r_nxt  <= NULL_PTR;
                        r_err  <= (rd_ptr == NULL_PTR);
                    end
                end
                S_ISSUE: begin
                    r_pend_data <= 1'b1;
                    r_pend_nxt  <= 1'b1;
                end
                S_WAIT_RD: begin
                    if (w_data_hit) begin
                        r_data      <= rd_data_from_ll_data_mem;
                        r_pend_data <= 1'b0;
                    end
                    if (w_nxt_hit) begin
                        r_nxt      <= nxt_ptr_rd_data;
                        r_pend_nxt <= 1'b0;
                    end
                    if (w_tmo) begin
                        r_pend_data <= 1'b0;
                        r_pend_nxt  <= 1'b0;
                        r_data      <= '0;
                        r_err       <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rd_ctrl_fsm_ready   = r_ready;
    assign rd_req2ll_data_mem  = r_issue;
    assign nxt_ptr_rd_req      = r_issue;
    assign rd_addr2ll_data_mem = r_ptr;
    assign nxt_ptr_rd_addr     = r_ptr;
    assign free_ptr            = r_ptr;
    assign free_ptr_vld        = r_free_vld;
    assign rd_data_out         = r_data;
    assign rd_nxt_ptr_out      = r_nxt;
    assign rd_err              = r_err;
    assign rd_resp_vld         = r_resp_vld;

endmodule

// File: tb/tb_ll_rd_ctrl.sv
// tb/tb_ll_rd_ctrl.sv - randomized self-checking bench for ll_rd_ctrl against a transaction-level model.
module tb_ll_rd_ctrl;

    localparam int         PW  = 8;
    localparam int         DW  = 32;
    localparam logic [7:0] NUL = 8'hFF;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rd_req;
    logic [PW-1:0] rd_ptr;
    logic          rd_ctrl_fsm_ready;
    logic          rd_req2ll_data_mem;
    logic [PW-1:0] rd_addr2ll_data_mem;
    logic [DW-1:0] rd_data_from_ll_data_mem;
    logic          rd_data_from_ll_data_mem_vld;
    logic          nxt_ptr_rd_req;
    logic [PW-1:0] nxt_ptr_rd_addr;
    logic [PW-1:0] nxt_ptr_rd_data;
    logic          nxt_ptr_rd_vld;
    logic [PW-1:0] free_ptr;
    logic          free_ptr_vld;
    logic          free_ptr_ack;
    logic [DW-1:0] rd_data_out;
    logic [PW-1:0] rd_nxt_ptr_out;
    logic          rd_err;
    logic          rd_resp_vld;
    logic          rd_resp_rdy;

    always #5 clk = ~clk;

    ll_rd_ctrl dut (
        .clk                          (clk),
        .reset_n                      (reset_n),
        .rd_req                       (rd_req),
        .rd_ptr                       (rd_ptr),
        .rd_ctrl_fsm_ready            (rd_ctrl_fsm_ready),
        .rd_req2ll_data_mem           (rd_req2ll_data_mem),
        .rd_addr2ll_data_mem          (rd_addr2ll_data_mem),
        .rd_data_from_ll_data_mem     (rd_data_from_ll_data_mem),
        .rd_data_from_ll_data_mem_vld (rd_data_from_ll_data_mem_vld),
        .nxt_ptr_rd_req               (nxt_ptr_rd_req),
        .nxt_ptr_rd_addr              (nxt_ptr_rd_addr),
        .nxt_ptr_rd_data              (nxt_ptr_rd_data),
        .nxt_ptr_rd_vld               (nxt_ptr_rd_vld),
        .free_ptr                     (free_ptr),
        .free_ptr_vld                 (free_ptr_vld),
        .free_ptr_ack                 (free_ptr_ack),
        .rd_data_out                  (rd_data_out),
        .rd_nxt_ptr_out               (rd_nxt_ptr_out),
        .rd_err                       (rd_err),
        .rd_resp_vld                  (rd_resp_vld),
        .rd_resp_rdy                  (rd_resp_rdy)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] data_mem [256];
    logic [PW-1:0] nxt_mem  [256];

    // Expectation of the pop currently being launched by the driver.
    logic [PW-1:0] exp_ptr;
    bit            exp_tmo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: owns its own copy of the expectation from the accept cycle onward.
    bit            in_flight, acc_next, hs_next;
    int            n_data, n_nxt, n_free;
    logic [PW-1:0] m_ptr;
    bit            m_null, m_tmo;

    always @(negedge clk) begin
        if (!reset_n) begin
            in_flight = 0;
            acc_next  = 0;
            hs_next   = 0;
        end else begin
            if (hs_next) begin
                check("ready_after_resp", 64'(rd_ctrl_fsm_ready), 64'd1);
                check("data_strobes", 64'(n_data), m_null ? 64'd0 : 64'd1);
                check("nxt_strobes", 64'(n_nxt), m_null ? 64'd0 : 64'd1);
                check("free_handshakes", 64'(n_free), (m_null || m_tmo) ? 64'd0 : 64'd1);
                hs_next   = 0;
                in_flight = 0;
            end
            if (acc_next) begin
                in_flight = 1;
                acc_next  = 0;
                n_data    = 0;
                n_nxt     = 0;
                n_free    = 0;
            end
            if (in_flight) begin
                check("ready_low_busy", 64'(rd_ctrl_fsm_ready), 64'd0);
                if (rd_req2ll_data_mem || nxt_ptr_rd_req) begin
                    n_data += int'(rd_req2ll_data_mem);
                    n_nxt  += int'(nxt_ptr_rd_req);
                    check("strobe_pair", 64'(rd_req2ll_data_mem), 64'(nxt_ptr_rd_req));
                    check("data_addr", 64'(rd_addr2ll_data_mem), 64'(m_ptr));
                    check("nxt_addr", 64'(nxt_ptr_rd_addr), 64'(m_ptr));
                end
                if (free_ptr_vld) begin
                    check("free_ptr", 64'(free_ptr), 64'(m_ptr));
                    if (free_ptr_ack) n_free++;
                end
                if (rd_resp_vld) begin
                    check("resp_data", 64'(rd_data_out),
                          (m_null || m_tmo) ? 64'd0 : 64'(data_mem[m_ptr]));
                    check("resp_nxt", 64'(rd_nxt_ptr_out),
                          (m_null || m_tmo) ? 64'(NUL) : 64'(nxt_mem[m_ptr]));
                    check("resp_err", 64'(rd_err), 64'(m_null || m_tmo));
                    if (rd_resp_rdy) hs_next = 1;
                end
            end else begin
                check("idle_quiet", 64'({rd_req2ll_data_mem, nxt_ptr_rd_req, free_ptr_vld, rd_resp_vld}), 64'd0);
            end
            if (rd_req && rd_ctrl_fsm_ready) begin
                acc_next = 1;
                m_ptr    = exp_ptr;
                m_null   = (exp_ptr == NUL);
                m_tmo    = exp_tmo;
            end
        end
    end

    task automatic clr_inputs();
        rd_req                       = 1'b0;
        rd_data_from_ll_data_mem_vld = 1'b0;
        nxt_ptr_rd_vld               = 1'b0;
        free_ptr_ack                 = 1'b0;
        rd_resp_rdy                  = 1'b0;
    endtask

    // One pop; dd/dn = return delay after the issue cycle, da/dr = ack/rdy wait in cycles.
    task automatic pop(input logic [PW-1:0] ptr, input int dd, input int dn, input int da, input int dr,
                       input bit tmo, input bit late,
                       output logic [DW-1:0] g_data, output logic [PW-1:0] g_nxt,
                       output logic g_err, output int lat);
        int            cyc, t_iss, fv, rv;
        bit            done, issued, late_done;
        logic [PW-1:0] a, na;
        cyc = 0;
        while (!rd_ctrl_fsm_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("ready_before_pop", 64'(rd_ctrl_fsm_ready), 64'd1);
        exp_ptr = ptr;
        exp_tmo = tmo;
        rd_ptr  = ptr;
        rd_req  = 1'b1;
        @(posedge clk); #1;
        rd_req = 1'b0;
        rd_ptr = PW'($urandom);
        cyc = 0; t_iss = 0; fv = 0; rv = 0; lat = -1;
        done = 0; issued = 0; late_done = 0; a = '0; na = '0;
        g_data = '0; g_nxt = '0; g_err = 1'b0;
        while (!done && cyc < 400) begin
            if (rd_req2ll_data_mem && !issued) begin
                issued = 1;
                t_iss  = cyc;
                a      = rd_addr2ll_data_mem;
                na     = nxt_ptr_rd_addr;
            end
            rd_data_from_ll_data_mem_vld = issued && (cyc == t_iss + dd);
            rd_data_from_ll_data_mem     = rd_data_from_ll_data_mem_vld ? data_mem[a] : DW'($urandom);
            nxt_ptr_rd_vld               = issued && (cyc == t_iss + dn);
            nxt_ptr_rd_data              = nxt_ptr_rd_vld ? nxt_mem[na] : PW'($urandom);
            if (late && rd_resp_vld && !late_done) begin
                rd_data_from_ll_data_mem_vld = 1'b1;
                nxt_ptr_rd_vld               = 1'b1;
                nxt_ptr_rd_data              = 8'h3C;
                late_done                    = 1;
            end
            free_ptr_ack = free_ptr_vld && (fv >= da);
            if (free_ptr_vld) fv++;
            if (rd_resp_vld) begin
                if (lat < 0) lat = cyc;
                g_data      = rd_data_out;
                g_nxt       = rd_nxt_ptr_out;
                g_err       = rd_err;
                rd_resp_rdy = (rv >= dr);
                done        = rd_resp_rdy;
                rv++;
            end else begin
                rd_resp_rdy = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        clr_inputs();
        if (!done) check("pop_completes", 64'd0, 64'd1);
    endtask

    logic [DW-1:0] g_data;
    logic [PW-1:0] g_nxt;
    logic          g_err;
    int            lat;

    initial begin
        for (int i = 0; i < 256; i++) begin
            data_mem[i] = $urandom;
            nxt_mem[i]  = PW'($urandom);
        end
        data_mem[5] = 32'hDEADBEEF;
        nxt_mem[5]  = 8'h09;
        nxt_mem[3]  = NUL;
        data_mem[2] = 32'h0000_1234;
        nxt_mem[2]  = 8'h44;
        exp_ptr = '0;
        exp_tmo = 0;
        rd_ptr  = '0;
        rd_data_from_ll_data_mem = '0;
        nxt_ptr_rd_data          = '0;
        clr_inputs();
        reset_n = 1'b0;
        #12;
        check("rst_ready", 64'(rd_ctrl_fsm_ready), 64'd1);
        check("rst_data", 64'(rd_data_out), 64'd0);
        check("rst_ctl", 64'({rd_req2ll_data_mem, rd_addr2ll_data_mem, nxt_ptr_rd_req, nxt_ptr_rd_addr,
                              free_ptr, free_ptr_vld, rd_nxt_ptr_out, rd_err, rd_resp_vld}), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic pop with literal expectations.
        pop(8'h05, 2, 1, 0, 0, 0, 0, g_data, g_nxt, g_err, lat);
        check("basic_data", 64'(g_data), 64'hDEADBEEF);
        check("basic_nxt", 64'(g_nxt), 64'h09);
        check("basic_err", 64'(g_err), 64'd0);

        // Return order: nxt after data, then both together.
        pop(8'h05, 1, 3, 0, 0, 0, 0, g_data, g_nxt, g_err, lat);
        check("order_data", 64'(g_data), 64'hDEADBEEF);
        pop(8'h05, 2, 2, 0, 0, 0, 0, g_data, g_nxt, g_err, lat);
        check("simul_nxt", 64'(g_nxt), 64'h09);

        // NULL pointer pop.
        pop(NUL, 1, 1, 0, 0, 0, 0, g_data, g_nxt, g_err, lat);
        check("null_err", 64'(g_err), 64'd1);
        check("null_nxt", 64'(g_nxt), 64'hFF);
        check("null_data", 64'(g_data), 64'd0);
        check("null_latency", 64'(lat), 64'd0);

        // Successor NULL is a normal pop.
        pop(8'h03, 1, 1, 0, 0, 0, 0, g_data, g_nxt, g_err, lat);
        check("nullsucc_nxt", 64'(g_nxt), 64'hFF);
        check("nullsucc_err", 64'(g_err), 64'd0);

        // Backpressure on free and response.
        pop(8'h05, 1, 2, 4, 3, 0, 0, g_data, g_nxt, g_err, lat);
        check("bp_data", 64'(g_data), 64'hDEADBEEF);

        // Reset in the middle of WAIT_RD, followed by a stale data return.
        exp_ptr = 8'h07;
        exp_tmo = 0;
        rd_ptr  = 8'h07;
        rd_req  = 1'b1;
        @(posedge clk); #1;
        rd_req = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("midrst_ready", 64'(rd_ctrl_fsm_ready), 64'd1);
        check("midrst_ctl", 64'({rd_req2ll_data_mem, nxt_ptr_rd_req, free_ptr_vld, rd_err, rd_resp_vld,
                                 rd_nxt_ptr_out}), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        rd_data_from_ll_data_mem_vld = 1'b1;
        rd_data_from_ll_data_mem     = 32'hBAD0BAD0;
        @(posedge clk); #1;
        rd_data_from_ll_data_mem_vld = 1'b0;
        @(posedge clk); #1;
        check("stale_data", 64'(rd_data_out), 64'd0);
        check("stale_ready", 64'(rd_ctrl_fsm_ready), 64'd1);
        pop(8'h02, 1, 2, 1, 0, 0, 0, g_data, g_nxt, g_err, lat);
        check("after_rst_data", 64'(g_data), 64'h1234);
        check("after_rst_nxt", 64'(g_nxt), 64'h44);

`ifdef LL_RD_TMO_EN
        pop(8'h11, 2, 100000, 0, 2, 1, 1, g_data, g_nxt, g_err, lat);
        check("tmo_err", 64'(g_err), 64'd1);
        check("tmo_data", 64'(g_data), 64'd0);
        check("tmo_nxt", 64'(g_nxt), 64'hFF);
        pop(8'h12, 1, 1, 0, 0, 0, 0, g_data, g_nxt, g_err, lat);
        check("post_tmo_data", 64'(g_data), 64'(data_mem[8'h12]));
`endif

        // Randomized pops; the monitor checks every one against the memory model.
        for (int n = 0; n < 40; n++) begin
            logic [PW-1:0] p;
            p = ($urandom_range(0, 7) == 0) ? NUL : PW'($urandom_range(0, 254));
            pop(p, $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 3),
                $urandom_range(0, 3), 0, 0, g_data, g_nxt, g_err, lat);
        end

        @(posedge clk); #1;
        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
